// File: rtl/des_crypt_unrolled.sv
// Iterative DES encrypt/decrypt core evaluating UNROLL rounds per clock.
// Block and 16x48-bit round-key bus enter and the IP^-1 result leaves over valid/ready handshakes.
module des_crypt_unrolled #(
  parameter int UNROLL = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         decrypt,
  input  logic [63:0]  message,
  input  logic [767:0] round_keys,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  result,
  output logic         busy
);

  localparam int NRUN = 16 / UNROLL;
  localparam logic [3:0] LAST = 4'(NRUN - 1);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
    $error("des_crypt_unrolled: UNROLL must be 1, 2, 4, 8 or 16");
  end

  // Tables use FIPS 46 numbering (bit 1 = MSB); vector bit [W-1] holds bit 1.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int IPINV_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  function automatic logic [63:0] ip_fn(input logic [63:0] x);
    logic [63:0] res;
    for (int i = 0; i < 64; i++) res[63-i] = x[64-IP_T[i]];
    return res;
  endfunction

  function automatic logic [63:0] ipinv_fn(input logic [63:0] x);
    logic [63:0] res;
    for (int i = 0; i < 64; i++) res[63-i] = x[64-IPINV_T[i]];
    return res;
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] res;
    logic [5:0]  b;
    int          idx;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    e = e ^ k;
    for (int n = 0; n < 8; n++) begin
      b   = e[47-6*n -: 6];
      idx = n*64 + int'({b[5], b[0]})*16 + int'(b[4:1]);
      s[31-4*n -: 4] = 4'(SBOX[idx]);
    end
    for (int i = 0; i < 32; i++) res[31-i] = s[32-P_T[i]];
    return res;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  logic [3:0]   rc;
  logic         dec_q;
  logic [767:0] keys_q;
  logic [31:0]  l_q, r_q, l_nxt, r_nxt;

  // Round datapath: key index j is 0-based (K1 = 0); decrypt walks K16 down to K1.
  always_comb begin : rounds
    logic [31:0] lw, rw, tmp;
    int          j;
    lw = l_q;
    rw = r_q;
    for (int u = 0; u < UNROLL; u++) begin
      j = int'(rc)*UNROLL + u;
      if (dec_q) j = 15 - j;
      tmp = rw;
      rw  = lw ^ f_fn(rw, keys_q[767-48*j -: 48]);
      lw  = tmp;
    end
    l_nxt = lw;
    r_nxt = rw;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      {l_q, r_q} <= ip_fn(message);
      keys_q     <= round_keys;
      dec_q      <= decrypt;
    end else if (state == RUN) begin
      l_q <= l_nxt;
      r_q <= r_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rc        <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state    <= RUN;
          rc       <= 4'd0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: if (rc == LAST) begin
          state     <= DONE;
          rc        <= 4'd0;
          out_valid <= 1'b1;
        end else begin
          rc <= rc + 4'd1;
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Final swap is absorbed by presenting {R16, L16} to IP^-1.
  assign result = ipinv_fn({r_q, l_q});

endmodule

// File: tb/tb_des_crypt_unrolled.sv
// Directed-vector bench driving four des_crypt_unrolled instances (UNROLL 1/2/4/16) in lockstep.
module tb_des_crypt_unrolled;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         decrypt;
  logic [63:0]  message;
  logic [767:0] round_keys;
  logic         out_ready;
  logic         ir [4];
  logic         ov [4];
  logic         bz [4];
  logic [63:0]  res [4];

  int checks = 0;
  int errors = 0;
  int nrun [4] = '{16, 8, 4, 1};

  always #5 clk = ~clk;

  des_crypt_unrolled #(.UNROLL(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .decrypt(decrypt), .message(message), .round_keys(round_keys), .out_valid(ov[0]),
    .out_ready(out_ready), .result(res[0]), .busy(bz[0]));
  des_crypt_unrolled #(.UNROLL(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .decrypt(decrypt), .message(message), .round_keys(round_keys), .out_valid(ov[1]),
    .out_ready(out_ready), .result(res[1]), .busy(bz[1]));
  des_crypt_unrolled #(.UNROLL(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .decrypt(decrypt), .message(message), .round_keys(round_keys), .out_valid(ov[2]),
    .out_ready(out_ready), .result(res[2]), .busy(bz[2]));
  des_crypt_unrolled #(.UNROLL(16)) u16 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
    .decrypt(decrypt), .message(message), .round_keys(round_keys), .out_valid(ov[3]),
    .out_ready(out_ready), .result(res[3]), .busy(bz[3]));

  // Subkeys of 133457799BBCDFF1, K1 first (most significant).
  localparam logic [767:0] KS_A = {
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  typedef struct {
    string        name;
    logic [63:0]  msg;
    logic [767:0] keys;
    logic         dec;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [3:0] pack4(input logic a0, input logic a1, input logic a2, input logic a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_block(input string name, input logic [63:0] msg, input logic [767:0] keys,
                           input logic dec, input logic chk, input logic [63:0] exp,
                           input int stall, output logic [63:0] got);
    logic        seen [4];
    logic [63:0] held [4];
    int          ncyc;
    got = '0;
    message = msg; round_keys = keys; decrypt = dec; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; message = ~msg; round_keys = ~keys; decrypt = ~dec;
    check({name, "_accept_in_ready"}, 64'(pack4(ir[0], ir[1], ir[2], ir[3])), 64'h0);
    for (int d = 0; d < 4; d++) begin seen[d] = 1'b0; held[d] = '0; end
    ncyc = (stall > 0) ? 16 + stall : 20;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (stall > 0 && cyc == 10) begin
        in_valid = 1'b1; message = 64'hDEADBEEFCAFEF00D;
      end
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        if (ov[d] && !seen[d]) begin
          seen[d] = 1'b1;
          held[d] = res[d];
          check($sformatf("%s_latency_u%0d", name, 16/nrun[d]), 64'(cyc), 64'(nrun[d]));
          if (chk) check($sformatf("%s_result_u%0d", name, 16/nrun[d]), res[d], exp);
          if (d == 1) got = res[d];
        end
      end
    end
    for (int d = 0; d < 4; d++)
      if (!seen[d]) check($sformatf("%s_timeout_u%0d", name, 16/nrun[d]), 64'(seen[d]), 64'h1);
    if (stall > 0) begin
      for (int d = 0; d < 4; d++) begin
        check($sformatf("%s_stall_hold_u%0d", name, 16/nrun[d]),
              {res[d][63:2], ov[d], ir[d]}, {held[d][63:2], 1'b1, 1'b0});
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check({name, "_release_out_valid"}, 64'(pack4(ov[0], ov[1], ov[2], ov[3])), 64'h0);
    end
    check({name, "_idle_in_ready"}, 64'(pack4(ir[0], ir[1], ir[2], ir[3])), 64'hF);
  endtask

  initial begin
    logic [63:0]  got, msg;
    logic [767:0] keys;
    logic         dec;

    vecs[0] = '{"enc_std",  64'h0123456789ABCDEF, KS_A,   1'b0, 64'h85E813540F0AB405};
    vecs[1] = '{"dec_std",  64'h85E813540F0AB405, KS_A,   1'b1, 64'h0123456789ABCDEF};
    vecs[2] = '{"enc_zero", 64'h0000000000000000, 768'h0, 1'b0, 64'h8CA64DE9C1B123A7};
    vecs[3] = '{"dec_zero", 64'h8CA64DE9C1B123A7, 768'h0, 1'b1, 64'h0000000000000000};

    rst_n = 1'b0; in_valid = 1'b0; decrypt = 1'b0; message = '0; round_keys = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready",  64'(pack4(ir[0], ir[1], ir[2], ir[3])), 64'hF);
    check("reset_out_valid", 64'(pack4(ov[0], ov[1], ov[2], ov[3])), 64'h0);
    check("reset_busy",      64'(pack4(bz[0], bz[1], bz[2], bz[3])), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      run_block(vecs[i].name, vecs[i].msg, vecs[i].keys, vecs[i].dec, 1'b1, vecs[i].exp, 0, got);

    run_block("backpressure", vecs[0].msg, vecs[0].keys, 1'b0, 1'b1, vecs[0].exp, 10, got);
    run_block("after_stall", vecs[1].msg, vecs[1].keys, 1'b1, 1'b1, vecs[1].exp, 0, got);

    // Abort a block in flight: u2 sits at rc=3, u16 already waits in DONE.
    message = vecs[0].msg; round_keys = KS_A; decrypt = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", 64'(pack4(bz[0], bz[1], bz[2], bz[3])), 64'hF);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrun_reset_out_valid", 64'(pack4(ov[0], ov[1], ov[2], ov[3])), 64'h0);
    check("midrun_reset_in_ready",  64'(pack4(ir[0], ir[1], ir[2], ir[3])), 64'hF);
    check("midrun_reset_busy",      64'(pack4(bz[0], bz[1], bz[2], bz[3])), 64'h0);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    run_block("post_reset", vecs[2].msg, vecs[2].keys, 1'b0, 1'b1, vecs[2].exp, 0, got);

    // Random round trips: the inverse operation must restore the original block.
    for (int i = 0; i < 20; i++) begin
      msg = {$urandom(), $urandom()};
      keys = '0;
      for (int k = 0; k < 24; k++) keys = {keys[735:0], 32'($urandom())};
      dec = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_block($sformatf("rand%0d_fwd", i), msg, keys, dec, 1'b0, 64'h0, int'($urandom_range(0, 3)), got);
      run_block($sformatf("rand%0d_inv", i), got, keys, ~dec, 1'b1, msg, 0, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
